// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter_ctrl run/pause/clear/load sequencer.
package counter_ctrl_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between the button front-end and the counter sequencer.
interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up;
  logic             wrap_en;
  logic [WIDTH-1:0] Q;
  logic             running;
  logic             tc;
  logic [ST_W-1:0]  state;

  modport master (
    output start, stop, clear, load, load_val, up, wrap_en,
    input  Q, running, tc, state
  );

  modport slave (
    input  start, stop, clear, load, load_val, up, wrap_en,
    output Q, running, tc, state
  );
endinterface

// File: rtl/counter_ctrl_rise_detect.sv
// Rising-edge detector turning a level input into a registered one-cycle command.
module rise_detect (
  input  logic Clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic in_d;

  // History clears on reset so a level held high through reset yields a pulse.
  always_ff @(posedge Clk) begin
    if (reset) begin
      in_d  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      in_d  <= in;
      pulse <= in & ~in_d;
    end
  end
endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/clear/load sequencer for the display event counter with prescaled ticks.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int          WIDTH    = 16,
  parameter int unsigned PRESCALE = 50000000,
  parameter int          PS_W     = 32
) (
  input  logic           Clk,
  input  logic           reset,
  counter_ctrl_if.slave  bus
);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic             cmd_start, cmd_stop, cmd_clear, cmd_load;
  logic [WIDTH-1:0] q, q_n;
  logic [PS_W-1:0]  ps, ps_n;
  logic [ST_W-1:0]  st, st_n;
  logic             tc_r, tc_n;
  logic             running_r;

  rise_detect u_rd_start (.Clk(Clk), .reset(reset), .in(bus.start), .pulse(cmd_start));
  rise_detect u_rd_stop  (.Clk(Clk), .reset(reset), .in(bus.stop),  .pulse(cmd_stop));
  rise_detect u_rd_clear (.Clk(Clk), .reset(reset), .in(bus.clear), .pulse(cmd_clear));
  rise_detect u_rd_load  (.Clk(Clk), .reset(reset), .in(bus.load),  .pulse(cmd_load));

  always_comb begin
    q_n  = q;
    ps_n = ps;
    st_n = st;
    tc_n = 1'b0;
    // Priority chain clear > load > stop > start; a start while running falls through to counting.
    if (cmd_clear) begin
      q_n  = '0;
      ps_n = '0;
      st_n = ST_IDLE;
    end else if (cmd_load) begin
      q_n  = bus.load_val;
      ps_n = '0;
      if (st == ST_DONE) st_n = ST_PAUSE;
    end else if (cmd_stop) begin
      if (st == ST_RUN) st_n = ST_PAUSE;
    end else if (cmd_start && st != ST_RUN) begin
      st_n = ST_RUN;
      if (st != ST_PAUSE) ps_n = '0;
    end else if (st == ST_RUN) begin
      if (ps == PS_MAX) begin
        ps_n = '0;
        if (bus.up) begin
          if (q == '1) begin
            tc_n = 1'b1;
            if (bus.wrap_en) q_n = '0;
            else             st_n = ST_DONE;
          end else begin
            q_n = q + WIDTH'(1);
          end
        end else begin
          if (q == '0) begin
            tc_n = 1'b1;
            if (bus.wrap_en) q_n = '1;
            else             st_n = ST_DONE;
          end else begin
            q_n = q - WIDTH'(1);
          end
        end
      end else begin
        ps_n = ps + PS_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      q         <= '0;
      ps        <= '0;
      st        <= ST_IDLE;
      tc_r      <= 1'b0;
      running_r <= 1'b0;
    end else begin
      q         <= q_n;
      ps        <= ps_n;
      st        <= st_n;
      tc_r      <= tc_n;
      running_r <= (st_n == ST_RUN);
    end
  end

  assign bus.Q       = q;
  assign bus.running = running_r;
  assign bus.tc      = tc_r;
  assign bus.state   = st;
endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: PRESCALE=4 instance plus a PRESCALE=1 instance.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [15:0] q;
    logic [1:0]  st;
    logic        run;
    logic        tc;
  } exp_t;

  logic Clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e;
  logic [15:0] aq;
  logic [1:0]  ast;
  logic        ar, at;
  int          base;

  counter_ctrl_if #(.WIDTH(16)) bus_a ();
  counter_ctrl_if #(.WIDTH(16)) bus_b ();

  counter_ctrl #(.WIDTH(16), .PRESCALE(4), .PS_W(32)) u_a (
    .Clk(Clk), .reset(rst_a), .bus(bus_a.slave));
  counter_ctrl #(.WIDTH(16), .PRESCALE(1), .PS_W(32)) u_b (
    .Clk(Clk), .reset(rst_b), .bus(bus_b.slave));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: checks every queued expectation on the negedge of its target cycle.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        aq = bus_a.Q; ast = bus_a.state; ar = bus_a.running; at = bus_a.tc;
      end else begin
        aq = bus_b.Q; ast = bus_b.state; ar = bus_b.running; at = bus_b.tc;
      end
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: check for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
      end else if ({aq, ast, ar, at} !== {e.q, e.st, e.run, e.tc}) begin
        fails++;
        $display("FAIL %s: cyc %0d got Q=%h state=%0d running=%b tc=%b, expected Q=%h state=%0d running=%b tc=%b",
                 e.name, cyc, aq, ast, ar, at, e.q, e.st, e.run, e.tc);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_at(input int c, input int d, input string nm, input logic [15:0] q,
                           input logic [1:0] s, input logic r, input logic t);
    exp_t x;
    x.cyc = c; x.dut = d; x.name = nm; x.q = q; x.st = s; x.run = r; x.tc = t;
    sb.push_back(x);
  endtask

  task automatic clear_a_inputs();
    bus_a.start = 0; bus_a.stop = 0; bus_a.clear = 0; bus_a.load = 0;
    bus_a.load_val = '0; bus_a.up = 1; bus_a.wrap_en = 1;
    bus_b.start = 0; bus_b.stop = 0; bus_b.clear = 0; bus_b.load = 0;
    bus_b.load_val = '0; bus_b.up = 1; bus_b.wrap_en = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_a_inputs();
    step(); step();

    // Reset state, then start and count up every 4 cycles.
    base = cyc;
    rst_a = 0;
    bus_a.start = 1;
    expect_at(base,      0, "reset_state",   16'h0000, ST_IDLE, 0, 0);
    expect_at(base + 1,  0, "start_latency", 16'h0000, ST_IDLE, 0, 0);
    expect_at(base + 2,  0, "run_entered",   16'h0000, ST_RUN,  1, 0);
    expect_at(base + 5,  0, "pre_tick",      16'h0000, ST_RUN,  1, 0);
    expect_at(base + 6,  0, "first_tick",    16'h0001, ST_RUN,  1, 0);
    expect_at(base + 14, 0, "third_tick",    16'h0003, ST_RUN,  1, 0);
    expect_at(base + 18, 0, "fourth_tick",   16'h0004, ST_RUN,  1, 0);
    step();
    bus_a.start = 0;
    wait_until(base + 18);

    // Load near max and wrap upward.
    base = cyc;
    bus_a.load_val = 16'hFFFE;
    bus_a.load = 1;
    expect_at(base + 2,  0, "load_fffe",     16'hFFFE, ST_RUN, 1, 0);
    expect_at(base + 6,  0, "to_ffff",       16'hFFFF, ST_RUN, 1, 0);
    expect_at(base + 9,  0, "hold_ffff",     16'hFFFF, ST_RUN, 1, 0);
    expect_at(base + 10, 0, "wrap_tc",       16'h0000, ST_RUN, 1, 1);
    expect_at(base + 11, 0, "tc_one_cycle",  16'h0000, ST_RUN, 1, 0);
    step();
    bus_a.load = 0;
    wait_until(base + 11);

    // Count down to zero and saturate into DONE.
    base = cyc;
    bus_a.up = 0;
    bus_a.wrap_en = 0;
    bus_a.load_val = 16'h0001;
    bus_a.load = 1;
    expect_at(base + 2,  0, "load_0001",     16'h0001, ST_RUN,  1, 0);
    expect_at(base + 6,  0, "down_to_0",     16'h0000, ST_RUN,  1, 0);
    expect_at(base + 10, 0, "saturate_tc",   16'h0000, ST_DONE, 0, 1);
    expect_at(base + 11, 0, "done_tc_clr",   16'h0000, ST_DONE, 0, 0);
    expect_at(base + 30, 0, "done_holds",    16'h0000, ST_DONE, 0, 0);
    step();
    bus_a.load = 0;
    wait_until(base + 30);

    // Restart from DONE, pause with prescaler at 2, resume.
    base = cyc;
    bus_a.up = 1;
    bus_a.wrap_en = 1;
    bus_a.start = 1;
    expect_at(base + 2,  0, "restart_run",   16'h0000, ST_RUN,   1, 0);
    expect_at(base + 4,  0, "before_stop",   16'h0000, ST_RUN,   1, 0);
    expect_at(base + 5,  0, "paused",        16'h0000, ST_PAUSE, 0, 0);
    expect_at(base + 8,  0, "pause_frozen",  16'h0000, ST_PAUSE, 0, 0);
    expect_at(base + 10, 0, "resumed",       16'h0000, ST_RUN,   1, 0);
    expect_at(base + 11, 0, "resume_no_tick",16'h0000, ST_RUN,   1, 0);
    expect_at(base + 12, 0, "resume_tick",   16'h0001, ST_RUN,   1, 0);
    step();
    bus_a.start = 0;
    wait_until(base + 3);
    bus_a.stop = 1;
    step();
    bus_a.stop = 0;
    wait_until(base + 8);
    bus_a.start = 1;
    step();
    bus_a.start = 0;
    wait_until(base + 12);

    // Clear and load together: clear wins.
    base = cyc;
    bus_a.load_val = 16'h1234;
    bus_a.clear = 1;
    bus_a.load = 1;
    expect_at(base + 1, 0, "pre_clear",      16'h0001, ST_RUN,  1, 0);
    expect_at(base + 2, 0, "clear_beats_ld", 16'h0000, ST_IDLE, 0, 0);
    expect_at(base + 6, 0, "idle_holds",     16'h0000, ST_IDLE, 0, 0);
    step();
    bus_a.clear = 0;
    bus_a.load = 0;
    wait_until(base + 6);

    // PRESCALE=1 instance: tick every RUN cycle, mid-run reset, start held through reset.
    base = cyc;
    rst_b = 0;
    bus_b.start = 1;
    expect_at(base,      1, "b_reset_state", 16'h0000, ST_IDLE, 0, 0);
    expect_at(base + 2,  1, "b_run",         16'h0000, ST_RUN,  1, 0);
    expect_at(base + 3,  1, "b_q1",          16'h0001, ST_RUN,  1, 0);
    expect_at(base + 7,  1, "b_q5",          16'h0005, ST_RUN,  1, 0);
    expect_at(base + 8,  1, "b_mid_reset",   16'h0000, ST_IDLE, 0, 0);
    expect_at(base + 9,  1, "b_after_rst",   16'h0000, ST_IDLE, 0, 0);
    expect_at(base + 10, 1, "b_held_start",  16'h0000, ST_RUN,  1, 0);
    step();
    bus_b.start = 0;
    wait_until(base + 7);
    rst_b = 1;
    bus_b.start = 1;
    step();
    rst_b = 0;
    wait_until(base + 10);

    step(); step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Run/pause/clear/load sequencer for the 16-bit event counter that drives the four-digit hex display (HEX3..HEX0, one nibble per digit).
- Turns push-button-style level inputs into one-cycle commands and gates counting with a programmable prescaler tick.
- Supports up/down counting, and wrap or saturate at the terminal count.
- Its Q output feeds the existing per-nibble 7-segment decoders unchanged.

Parameters:
- WIDTH, 16, counter width in bits; must be a multiple of 4 for the display.
- PRESCALE, 50000000, clock cycles per count tick (1 Hz at 50 MHz); legal range 1 to 2^32-1.
- PS_W, 32, prescaler register width; must hold PRESCALE-1.

Ports:
- Clk  in  1  system clock, all state changes on its rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  level input; a rising edge issues a start command
- stop  in  1  level input; a rising edge issues a pause command
- clear  in  1  level input; a rising edge zeroes the count
- load  in  1  level input; a rising edge loads load_val
- load_val  in  WIDTH  value captured by a load command
- up  in  1  1 = count up, 0 = count down; sampled at each tick
- wrap_en  in  1  1 = wrap at terminal count, 0 = saturate and stop
- Q  out  WIDTH  current count value
- running  out  1  high while in the RUN state
- tc  out  1  one-cycle pulse when a terminal count is reached
- state  out  2  FSM state, for debug LEDs

Behaviour:
- Reset: applies at the Clk edge while reset=1. Q=0, state=IDLE, running=0, tc=0, prescaler=0. Edge-detector history registers are set to 0, so an input held high through reset produces a rising edge on the first cycle after reset is released.
- Commands: cmd_x = x & ~x_d, where x_d is x registered once. A command acts on the cycle after the input edge is sampled. Input synchronisation/debounce is external.
- Command priority when several occur in the same cycle: clear > load > stop > start. Only the highest-priority command acts; the others are dropped.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - IDLE: start -> RUN, prescaler cleared to 0.
  - RUN: stop -> PAUSE, prescaler value retained. Saturating terminal count -> DONE.
  - PAUSE: start -> RUN, prescaler resumes from its retained value.
  - DONE: start -> RUN, prescaler cleared to 0. Q is unchanged, so a down-counter sitting at 0 (or an up-counter at max) immediately re-saturates at the next tick.
- clear in any state: Q=0, prescaler=0, state=IDLE.
- load in any state: Q=load_val, prescaler=0. State is kept, except DONE goes to PAUSE.
- Prescaler:
  - Advances only in RUN.
  - tick=1 when prescaler==PRESCALE-1; the prescaler then returns to 0.
  - PRESCALE=1 gives a tick every RUN cycle.
- On a tick:
  - up=1 and Q==2^WIDTH-1: terminal count. wrap_en=1 gives Q=0, tc=1. wrap_en=0 holds Q, sets tc=1 and state=DONE.
  - up=0 and Q==0: terminal count. wrap_en=1 gives Q=2^WIDTH-1, tc=1. wrap_en=0 holds Q, sets tc=1 and state=DONE.
  - Otherwise Q = Q ± 1, computed modulo 2^WIDTH with no carry out.
- Latency: tc and the new Q appear in the same cycle, one Clk after the tick condition. running equals (state==RUN) and is registered.
- A stop command and a tick in the same cycle: the stop wins; no count occurs and the prescaler holds.
- Changing up or wrap_en mid-run takes effect at the next tick.
- reset asserted mid-operation overrides everything in that cycle.

Decomposition:
- Shared package counter_ctrl_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and the 2-bit state width constant.
- One natural sub-module: rise_detect, 1-bit, with ports Clk, reset, in, pulse. Instantiated four times (start, stop, clear, load).
- Prescaler, FSM and counter datapath stay in counter_ctrl.

Test Plan (PRESCALE=4 unless stated):
- Reset, then a start edge, up=1, wrap_en=1 -> running=1 two cycles later; Q increments every 4 cycles: 0,1,2,3 after 16 cycles of RUN.
- load_val=16'hFFFE, load, start, up=1, wrap_en=1 -> Q goes FFFE, FFFF, 0000; tc pulses exactly 1 cycle at 0000; state stays RUN.
- Q=16'h0001, up=0, wrap_en=0, running -> Q goes 0000, tc=1, state=DONE; Q stays 0000 for 20 further cycles.
- Running with prescaler at 2, stop edge -> PAUSE, Q frozen; start edge -> next tick arrives after exactly 1 RUN cycle (prescaler resumed at 2, tick at 3), not 4.
- clear and load edges in the same cycle while running -> Q=0, state=IDLE; load_val is ignored.
- PRESCALE=1: start, 5 RUN cycles -> Q=5. Assert reset for 1 cycle mid-run -> Q=0, state=IDLE, running=0, tc=0 next cycle.
